// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and constants for the March C- BIST engine.
// Holds the FSM state enum, the element descriptor and its constant table,
// and the data-background units used to build D0.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_t;

    typedef logic [2:0] elem_idx_t;

    localparam elem_idx_t LAST_ELEM = 3'd5;

    // Background is built by replicating a 2-bit unit across the word.
    localparam logic [1:0] BG_SOLID_UNIT   = 2'b00;
    localparam logic [1:0] BG_CHECKER_UNIT = 2'b01;

    // read_sel / write_sel: 0 selects D0, 1 selects D1 = ~D0.
    typedef struct packed {
        logic down;
        logic has_read;
        logic read_sel;
        logic has_write;
        logic write_sel;
    } elem_desc_t;

    // Constant March C- table, M0..M5.
    function automatic elem_desc_t elem_desc(input elem_idx_t e);
        elem_desc_t d;
        case (e)
            3'd0:    d = '{down: 1'b0, has_read: 1'b0, read_sel: 1'b0, has_write: 1'b1, write_sel: 1'b0};
            3'd1:    d = '{down: 1'b0, has_read: 1'b1, read_sel: 1'b0, has_write: 1'b1, write_sel: 1'b1};
            3'd2:    d = '{down: 1'b0, has_read: 1'b1, read_sel: 1'b1, has_write: 1'b1, write_sel: 1'b0};
            3'd3:    d = '{down: 1'b1, has_read: 1'b1, read_sel: 1'b0, has_write: 1'b1, write_sel: 1'b1};
            3'd4:    d = '{down: 1'b1, has_read: 1'b1, read_sel: 1'b1, has_write: 1'b1, write_sel: 1'b0};
            3'd5:    d = '{down: 1'b0, has_read: 1'b1, read_sel: 1'b0, has_write: 1'b0, write_sel: 1'b0};
            default: d = '{down: 1'b0, has_read: 1'b0, read_sel: 1'b0, has_write: 1'b0, write_sel: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_bist_seq.sv
// mem_bist_seq: March C- command sequencer.
// Walks backgrounds, elements and addresses, and emits per-cycle read, write
// and compare commands. Read elements are pipelined: the step that reads
// address a+1 also compares and writes address a, plus one drain step at the
// end. Defining MBIST_BACKGROUND_EN adds a checkerboard pass after the solid one.
module mem_bist_seq
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cmp_en,
    output logic [ADDR_W-1:0] cmp_addr,
    output logic [DATA_W-1:0] cmp_data,
    output logic [2:0]        cur_elem,
    output logic              cur_bg,
    output logic              last_cycle
);

    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   DEPTH_M1  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [DATA_W-1:0] PAT_SOLID = {(DATA_W/2){BG_SOLID_UNIT}};
    localparam logic [DATA_W-1:0] PAT_CHECK = {(DATA_W/2){BG_CHECKER_UNIT}};

    elem_idx_t         elem;
    logic [ADDR_W:0]   step;
    logic [ADDR_W:0]   step_prev;
    logic              bg;
    logic              pass_last;
    elem_desc_t        desc;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] addr_prev;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic              elem_end;

    assign desc      = elem_desc(elem);
    assign step_prev = step - 1'b1;
    assign addr_cur  = desc.down ? ~step[ADDR_W-1:0]      : step[ADDR_W-1:0];
    assign addr_prev = desc.down ? ~step_prev[ADDR_W-1:0] : step_prev[ADDR_W-1:0];
    assign d0        = bg ? PAT_CHECK : PAT_SOLID;
    assign d1        = ~d0;

    // Read elements need one extra drain step to compare/write the last address.
    assign elem_end   = desc.has_read ? (step == DEPTH) : (step == DEPTH_M1);
    assign last_cycle = run && elem_end && (elem == LAST_ELEM) && pass_last;
    assign cur_elem   = elem;
    assign cur_bg     = bg;

    // Decode the current step into memory commands.
    always_comb begin
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        cmp_en   = 1'b0;
        rd_addr  = addr_cur;
        cmp_addr = addr_prev;
        wr_addr  = desc.has_read ? addr_prev : addr_cur;
        wr_data  = desc.write_sel ? d1 : d0;
        cmp_data = desc.read_sel ? d1 : d0;
        if (run) begin
            if (desc.has_read) begin
                rd_en  = (step != DEPTH);
                cmp_en = (step != '0);
                wr_en  = desc.has_write && (step != '0);
            end else begin
                wr_en  = desc.has_write;
            end
        end
    end

    // Step and element counters; parked at zero whenever the engine is not running.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            step <= '0;
            elem <= '0;
        end else if (elem_end) begin
            step <= '0;
            elem <= (elem == LAST_ELEM) ? '0 : elem + 1'b1;
        end else begin
            step <= step + 1'b1;
        end
    end

`ifdef MBIST_BACKGROUND_EN
    assign pass_last = bg;

    // Background toggles to checkerboard once the solid pass finishes.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            bg <= 1'b0;
        end else if (elem_end && (elem == LAST_ELEM)) begin
            bg <= ~bg;
        end
    end
`else
    assign pass_last = 1'b1;
    assign bg        = 1'b0;
`endif

endmodule

// File: rtl/mem_1r1w_bist_32x64.sv
// mem_1r1w_bist_32x64: March C- BIST wrapper in front of a 1R1W memory.
// Passes the functional ports through when idle; on start it owns both memory
// ports, runs the march and records the first failing address/element/background.
// Optional checkerboard pass: define MBIST_BACKGROUND_EN.
//
// state   | meaning
// IDLE    | after reset, passthrough, waiting for start
// RUN     | engine owns memory ports, march in progress
// DONE    | run complete, results held, passthrough, start reruns
module mem_1r1w_bist_32x64
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              fail_bg,
    input  logic [ADDR_W-1:0] f_R0_addr,
    input  logic              f_R0_en,
    output logic [DATA_W-1:0] f_R0_data,
    input  logic [ADDR_W-1:0] f_W0_addr,
    input  logic              f_W0_en,
    input  logic [DATA_W-1:0] f_W0_data,
    input  logic [MASK_W-1:0] f_W0_mask,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [DATA_W-1:0] R0_data,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [DATA_W-1:0] W0_data,
    output logic [MASK_W-1:0] W0_mask
);

    bist_state_t       state;
    logic              seq_rd_en;
    logic [ADDR_W-1:0] seq_rd_addr;
    logic              seq_wr_en;
    logic [ADDR_W-1:0] seq_wr_addr;
    logic [DATA_W-1:0] seq_wr_data;
    logic              seq_cmp_en;
    logic [ADDR_W-1:0] seq_cmp_addr;
    logic [DATA_W-1:0] seq_cmp_data;
    logic [2:0]        seq_elem;
    logic              seq_bg;
    logic              seq_last;
    logic              mismatch;

    mem_bist_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_seq (
        .clock      (clock),
        .reset      (reset),
        .run        (busy),
        .rd_en      (seq_rd_en),
        .rd_addr    (seq_rd_addr),
        .wr_en      (seq_wr_en),
        .wr_addr    (seq_wr_addr),
        .wr_data    (seq_wr_data),
        .cmp_en     (seq_cmp_en),
        .cmp_addr   (seq_cmp_addr),
        .cmp_data   (seq_cmp_data),
        .cur_elem   (seq_elem),
        .cur_bg     (seq_bg),
        .last_cycle (seq_last)
    );

    // Memory port mux: engine while busy, functional ports otherwise.
    always_comb begin
        R0_addr = busy ? seq_rd_addr : f_R0_addr;
        R0_en   = busy ? seq_rd_en   : f_R0_en;
        W0_addr = busy ? seq_wr_addr : f_W0_addr;
        W0_en   = busy ? seq_wr_en   : f_W0_en;
        W0_data = busy ? seq_wr_data : f_W0_data;
        W0_mask = busy ? {MASK_W{1'b1}} : f_W0_mask;
    end

    assign f_R0_data = R0_data;
    assign mismatch  = seq_cmp_en && (R0_data != seq_cmp_data);

    // Run-control FSM with first-mismatch capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_bg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        fail_bg   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (mismatch && !fail) begin
                        fail      <= 1'b1;
                        fail_addr <= seq_cmp_addr;
                        fail_elem <= seq_elem;
                        fail_bg   <= seq_bg;
                    end
                    if (seq_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
